// File: rtl/axi_read_arbiter_if.sv
// rtl/axi_read_arbiter_if.sv - AXI read-path bundle (AR + R channels) for one link
interface axi_read_arbiter_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [7:0]               arlen;
  logic [2:0]               arsize;
  logic [1:0]               arburst;
  logic                     arvalid;
  logic                     arready;
  logic [DATA_WIDTH-1:0]    rdata;
  logic [1:0]               rresp;
  logic                     rlast;
  logic                     rvalid;
  logic                     rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - two-master round-robin arbiter for the AXI read path
module axi_read_arbiter #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic               aclk,
  input  logic               areset,
  axi_read_arbiter_if.slave  m0,
  axi_read_arbiter_if.slave  m1,
  axi_read_arbiter_if.master s,
  output logic               grant_id,
  output logic               busy,
  output logic               protocol_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic [7:0]  len_q, len_d;
  logic [8:0]  beat_q, beat_d;
  logic        err_q, err_d;

  logic [ADDRESS_WIDTH-1:0] sel_araddr;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [7:0]               sel_arlen;
  logic                     sel_arvalid;
  logic                     sel_rready;
  logic                     beat_last;
  logic                     ar_hs;
  logic                     r_hs;

  // Pick the granted master's request fields and R ready; derive handshakes
  always_comb begin
    sel_araddr  = grant_q ? m1.araddr  : m0.araddr;
    sel_arlen   = grant_q ? m1.arlen   : m0.arlen;
    sel_arvalid = grant_q ? m1.arvalid : m0.arvalid;
    sel_rready  = grant_q ? m1.rready  : m0.rready;
    beat_last   = (beat_q == {1'b0, len_q});
    ar_hs       = (state_q == ADDR) && sel_arvalid && s.arready;
    r_hs        = (state_q == DATA) && s.rvalid && sel_rready;
  end

  // Bus outputs: AR is exposed only in ADDR, R only in DATA, nothing while in reset
  always_comb begin
    s.araddr   = sel_araddr;
    s.arlen    = sel_arlen;
    s.arsize   = grant_q ? m1.arsize  : m0.arsize;
    s.arburst  = grant_q ? m1.arburst : m0.arburst;
    r_data     = s.rdata;
    m0.rdata   = r_data;
    m1.rdata   = r_data;
    m0.rresp   = s.rresp;
    m1.rresp   = s.rresp;
    s.arvalid  = 1'b0;
    m0.arready = 1'b0;
    m1.arready = 1'b0;
    s.rready   = 1'b0;
    m0.rvalid  = 1'b0;
    m1.rvalid  = 1'b0;
    m0.rlast   = 1'b0;
    m1.rlast   = 1'b0;
    if (!areset) begin
      if (state_q == ADDR) begin
        s.arvalid  = sel_arvalid;
        m0.arready = !grant_q && s.arready;
        m1.arready = grant_q && s.arready;
      end
      if (state_q == DATA) begin
        s.rready  = sel_rready;
        m0.rvalid = !grant_q && s.rvalid;
        m1.rvalid = grant_q && s.rvalid;
        m0.rlast  = !grant_q && beat_last;
        m1.rlast  = grant_q && beat_last;
      end
    end
  end

  // Next state: registered arbitration, AR forwarding, count-terminated data phase
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    len_d        = len_q;
    beat_d       = beat_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (m0.arvalid || m1.arvalid) begin
          grant_d = (m0.arvalid && m1.arvalid) ? ~last_grant_q : m1.arvalid;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (ar_hs) begin
          len_d   = sel_arlen;
          beat_d  = 9'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (r_hs) begin
          beat_d = beat_q + 9'd1;
          if (s.rlast != beat_last) begin
            err_d = 1'b1;
          end
          if (beat_last) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; last_grant resets to 1 so M0 wins the first tie
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      len_q        <= 8'd0;
      beat_q       <= 9'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
    end
  end

  assign grant_id     = grant_q;
  assign busy         = (state_q != IDLE);
  assign protocol_err = err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - randomized self-checking bench for axi_read_arbiter
module tb_axi_read_arbiter;
  logic aclk, areset, grant_id, busy, protocol_err;

  axi_read_arbiter_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) m0_if ();
  axi_read_arbiter_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) m1_if ();
  axi_read_arbiter_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) s_if ();

  axi_read_arbiter #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset), .m0(m0_if), .m1(m1_if), .s(s_if),
    .grant_id(grant_id), .busy(busy), .protocol_err(protocol_err)
  );

  int n_checks, n_errors, cyc;
  int ar_pct, rv_pct, inj_beat;
  int rr_pct [2];
  bit data_open, cur_owner, prev_sarv, prev_err;
  int slv_len, slv_beat;
  logic [31:0] slv_data;
  logic [1:0]  slv_resp;
  int ar_mst_q[$], ar_len_q[$], lb_q[$], rise_q[$];
  int beats [2], last_seen [2], last_bad [2], data_bad [2];
  int stray, err_rise_cyc, inj_hs_cyc;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  // Slave + master behaviour and event logging for one clock; returns at the sample point
  task automatic step();
    bit dm0, dm1, rst, s_hs, exp_last;
    exp_last = (slv_beat == slv_len);
    s_hs = s_if.rvalid && s_if.rready;
    if ((m0_if.rvalid && !(data_open && !cur_owner)) || (m1_if.rvalid && !(data_open && cur_owner))) stray++;
    if ((m0_if.arready || m1_if.arready || s_if.arvalid) && data_open) stray++;
    if (m0_if.arready && m1_if.arready) stray++;
    if (s_if.rready && !data_open) stray++;
    if (s_hs != ((m0_if.rvalid && m0_if.rready) || (m1_if.rvalid && m1_if.rready))) stray++;
    if (m0_if.rvalid && m0_if.rready) begin
      beats[0]++;
      if (m0_if.rlast) last_seen[0]++;
      if (m0_if.rlast != exp_last) last_bad[0]++;
      if (m0_if.rdata !== slv_data || m0_if.rresp !== slv_resp) data_bad[0]++;
    end
    if (m1_if.rvalid && m1_if.rready) begin
      beats[1]++;
      if (m1_if.rlast) last_seen[1]++;
      if (m1_if.rlast != exp_last) last_bad[1]++;
      if (m1_if.rdata !== slv_data || m1_if.rresp !== slv_resp) data_bad[1]++;
    end
    if (s_hs && data_open) begin
      if (slv_beat == inj_beat) inj_hs_cyc = cyc;
      if (exp_last) begin
        data_open = 1'b0;
        lb_q.push_back(cyc);
      end
      slv_beat++;
    end
    if (s_if.arvalid && !prev_sarv) rise_q.push_back(cyc);
    prev_sarv = s_if.arvalid;
    if (protocol_err && !prev_err) err_rise_cyc = cyc;
    prev_err = protocol_err;
    if (s_if.arvalid && s_if.arready) begin
      ar_mst_q.push_back(m1_if.arready ? 1 : 0);
      ar_len_q.push_back(int'(s_if.arlen));
      cur_owner = m1_if.arready;
      data_open = 1'b1;
      slv_len   = int'(s_if.arlen);
      slv_beat  = 0;
    end
    dm0 = m0_if.arvalid && m0_if.arready;
    dm1 = m1_if.arvalid && m1_if.arready;
    rst = areset;
    @(posedge aclk);
    cyc++;
    @(negedge aclk);
    if (dm0 || rst) m0_if.arvalid = 1'b0;
    if (dm1 || rst) m1_if.arvalid = 1'b0;
    if (rst) data_open = 1'b0;
    s_if.arready = (int'($urandom_range(99)) < ar_pct);
    if (data_open) begin
      s_if.rvalid = (int'($urandom_range(99)) < rv_pct);
      s_if.rdata  = $urandom;
      s_if.rresp  = 2'($urandom_range(3));
      s_if.rlast  = (slv_beat == slv_len) ^ (slv_beat == inj_beat);
    end else begin
      s_if.rvalid = 1'b0;
      s_if.rlast  = 1'b0;
    end
    slv_data = s_if.rdata;
    slv_resp = s_if.rresp;
    m0_if.rready = (int'($urandom_range(99)) < rr_pct[0]);
    m1_if.rready = (int'($urandom_range(99)) < rr_pct[1]);
    #1;
  endtask

  task automatic clear_logs();
    ar_mst_q.delete();
    ar_len_q.delete();
    lb_q.delete();
    rise_q.delete();
    for (int i = 0; i < 2; i++) begin
      beats[i] = 0; last_seen[i] = 0; last_bad[i] = 0; data_bad[i] = 0;
    end
    stray = 0;
    err_rise_cyc = -100;
    inj_hs_cyc = -200;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    m0_if.arvalid = 1'b0;
    m1_if.arvalid = 1'b0;
    step();
    step();
    areset = 1'b0;
    step();
    clear_logs();
  endtask

  task automatic req(input int m, input int addr, input int len);
    if (m == 0) begin
      m0_if.araddr = 8'(addr); m0_if.arlen = 8'(len); m0_if.arsize = 3'd2; m0_if.arburst = 2'd1; m0_if.arvalid = 1'b1;
    end else begin
      m1_if.araddr = 8'(addr); m1_if.arlen = 8'(len); m1_if.arsize = 3'd2; m1_if.arburst = 2'd1; m1_if.arvalid = 1'b1;
    end
    #1;
  endtask

  task automatic run_until_idle(input int max, output bit to);
    int n;
    n = 0;
    while ((data_open || m0_if.arvalid || m1_if.arvalid) && n < max) begin
      step();
      n++;
    end
    to = (n >= max);
  endtask

  function automatic int seq_code(input int q[$]);
    int c;
    c = 0;
    foreach (q[i]) c = c * 10 + q[i] + 1;
    return c;
  endfunction

  task automatic test_reset();
    areset = 1'b1;
    m0_if.arvalid = 1'b1; m0_if.araddr = 8'h33; m1_if.arvalid = 1'b1;
    s_if.arready = 1'b1; s_if.rvalid = 1'b1; m0_if.rready = 1'b1; m1_if.rready = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    #1;
    n_checks++; if (s_if.arvalid !== 1'b0) begin n_errors++; $display("FAIL reset_s_arvalid: got %0b want 0", s_if.arvalid); end
    n_checks++; if ({m0_if.arready, m1_if.arready} !== 2'b00) begin n_errors++; $display("FAIL reset_m_arready: got %02b want 00", {m0_if.arready, m1_if.arready}); end
    n_checks++; if ({m0_if.rvalid, m1_if.rvalid, s_if.rready} !== 3'b000) begin n_errors++; $display("FAIL reset_rvalid_rready: got %03b want 000", {m0_if.rvalid, m1_if.rvalid, s_if.rready}); end
    n_checks++; if ({busy, grant_id, protocol_err} !== 3'b000) begin n_errors++; $display("FAIL reset_status: busy/grant/err got %03b want 000", {busy, grant_id, protocol_err}); end
    m0_if.arvalid = 1'b0; m1_if.arvalid = 1'b0; s_if.rvalid = 1'b0; s_if.arready = 1'b0;
    areset = 1'b0;
    step();
    clear_logs();
    n_checks++; if ({busy, grant_id, protocol_err} !== 3'b000) begin n_errors++; $display("FAIL post_reset_idle: busy/grant/err got %03b want 000", {busy, grant_id, protocol_err}); end
  endtask

  task automatic test_single_burst();
    bit to;
    do_reset();
    req(0, 'h10, 3);
    n_checks++; if (s_if.arvalid !== 1'b0) begin n_errors++; $display("FAIL single_ar_same_cycle: got %0b want 0", s_if.arvalid); end
    step();
    n_checks++; if (s_if.arvalid !== 1'b1) begin n_errors++; $display("FAIL single_ar_latency: got %0b want 1", s_if.arvalid); end
    n_checks++; if ({s_if.araddr, s_if.arlen, s_if.arsize} !== {8'h10, 8'd3, 3'd2}) begin n_errors++; $display("FAIL single_ar_fields: got %0h/%0d/%0d want 10/3/2", s_if.araddr, s_if.arlen, s_if.arsize); end
    run_until_idle(200, to);
    n_checks++; if (to) begin n_errors++; $display("FAIL single_timeout: still busy after 200 cycles, want idle"); end
    n_checks++; if (beats[0] != 4 || beats[1] != 0) begin n_errors++; $display("FAIL single_beats: got m0=%0d m1=%0d want 4/0", beats[0], beats[1]); end
    n_checks++; if (last_seen[0] != 1 || last_bad[0] != 0) begin n_errors++; $display("FAIL single_rlast: got count=%0d misplaced=%0d want 1/0", last_seen[0], last_bad[0]); end
    n_checks++; if (data_bad[0] != 0 || stray != 0) begin n_errors++; $display("FAIL single_routing: got data_bad=%0d stray=%0d want 0/0", data_bad[0], stray); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL single_busy_after: got %0b want 0", busy); end
  endtask

  task automatic test_round_robin();
    bit to;
    do_reset();
    req(0, 'h20, 1); req(1, 'h40, 1);
    run_until_idle(300, to);
    req(0, 'h21, 0); req(1, 'h41, 2);
    run_until_idle(300, to);
    req(0, 'h22, 1);
    run_until_idle(300, to);
    req(0, 'h23, 0); req(1, 'h43, 0);
    run_until_idle(300, to);
    n_checks++; if (to) begin n_errors++; $display("FAIL rr_timeout: still busy, want idle"); end
    n_checks++; if (seq_code(ar_mst_q) != 1212121) begin n_errors++; $display("FAIL rr_order: got code %0d want 1212121", seq_code(ar_mst_q)); end
    n_checks++; if (last_bad[0] + last_bad[1] + stray != 0) begin n_errors++; $display("FAIL rr_rlast_stray: got %0d want 0", last_bad[0] + last_bad[1] + stray); end
  endtask

  task automatic test_back_to_back();
    bit to;
    int n, gap;
    do_reset();
    req(0, 'h30, 3);
    n = 0;
    while (!data_open && n < 100) begin step(); n++; end
    req(1, 'h50, 2);
    n = 0;
    while (data_open && n < 200) begin
      n_checks++; if (m1_if.arready !== 1'b0) begin n_errors++; $display("FAIL b2b_m1_arready: got %0b want 0 during m0 data", m1_if.arready); end
      step();
      n++;
    end
    run_until_idle(300, to);
    n_checks++; if (to) begin n_errors++; $display("FAIL b2b_timeout: still busy, want idle"); end
    n_checks++; if (seq_code(ar_mst_q) != 12) begin n_errors++; $display("FAIL b2b_order: got code %0d want 12", seq_code(ar_mst_q)); end
    gap = (rise_q.size() >= 2 && lb_q.size() >= 1) ? rise_q[1] - lb_q[0] : -1;
    n_checks++; if (gap != 2) begin n_errors++; $display("FAIL b2b_bubble: last beat to m1 s_arvalid got %0d want 2 cycles", gap); end
    n_checks++; if (beats[1] != 3 || last_seen[1] != 1) begin n_errors++; $display("FAIL b2b_m1_beats: got %0d/%0d want 3/1", beats[1], last_seen[1]); end
  endtask

  task automatic test_long_burst();
    bit to;
    do_reset();
    rr_pct[1] = 50;
    req(1, 'h80, 255);
    run_until_idle(4000, to);
    rr_pct[1] = 100;
    n_checks++; if (to) begin n_errors++; $display("FAIL long_timeout: still busy, want idle"); end
    n_checks++; if (beats[1] != 256) begin n_errors++; $display("FAIL long_beats: got %0d want 256", beats[1]); end
    n_checks++; if (last_seen[1] != 1 || last_bad[1] != 0) begin n_errors++; $display("FAIL long_rlast: got count=%0d misplaced=%0d want 1/0", last_seen[1], last_bad[1]); end
    n_checks++; if (protocol_err !== 1'b0) begin n_errors++; $display("FAIL long_protocol_err: got %0b want 0", protocol_err); end
  endtask

  task automatic test_rlast_err();
    bit to;
    do_reset();
    inj_beat = 1;
    req(0, 'h60, 3);
    run_until_idle(200, to);
    inj_beat = -1;
    n_checks++; if (to) begin n_errors++; $display("FAIL err_timeout: still busy, want idle"); end
    n_checks++; if (err_rise_cyc - inj_hs_cyc != 1) begin n_errors++; $display("FAIL err_timing: rise after bad beat got %0d want 1", err_rise_cyc - inj_hs_cyc); end
    n_checks++; if (beats[0] != 4 || last_bad[0] != 0) begin n_errors++; $display("FAIL err_count_end: got beats=%0d misplaced=%0d want 4/0", beats[0], last_bad[0]); end
    repeat (5) step();
    n_checks++; if (protocol_err !== 1'b1) begin n_errors++; $display("FAIL err_sticky: got %0b want 1", protocol_err); end
    do_reset();
    n_checks++; if (protocol_err !== 1'b0) begin n_errors++; $display("FAIL err_clear: got %0b want 0", protocol_err); end
  endtask

  task automatic test_midburst_reset();
    int n;
    bit hit;
    do_reset();
    req(0, 'h70, 3);
    hit = 1'b0;
    n = 0;
    while (!hit && n < 200) begin
      step();
      n++;
      hit = data_open && slv_beat == 1 && s_if.rvalid && s_if.rready;
    end
    n_checks++; if (!hit) begin n_errors++; $display("FAIL mid_find_beat2: beat 2 not seen, want seen"); end
    areset = 1'b1;
    step();
    areset = 1'b0;
    #1;
    n_checks++; if ({busy, grant_id, protocol_err} !== 3'b000) begin n_errors++; $display("FAIL mid_status: busy/grant/err got %03b want 000", {busy, grant_id, protocol_err}); end
    s_if.rvalid = 1'b1; s_if.arready = 1'b1; m0_if.rready = 1'b1;
    #1;
    n_checks++; if ({s_if.arvalid, m0_if.arready, m1_if.arready, m0_if.rvalid, m1_if.rvalid, s_if.rready} !== 6'b0) begin
      n_errors++; $display("FAIL mid_outputs: got %06b want 000000", {s_if.arvalid, m0_if.arready, m1_if.arready, m0_if.rvalid, m1_if.rvalid, s_if.rready});
    end
    s_if.rvalid = 1'b0;
    step();
  endtask

  task automatic test_random();
    bit to;
    int model_last, sel, l0, l1, first;
    int exp_m[$], exp_l[$];
    int exp_beats [2];
    int exp_bursts [2];
    do_reset();
    model_last = 1;
    exp_beats = '{0, 0};
    exp_bursts = '{0, 0};
    repeat (10) begin
      sel = int'($urandom_range(1, 3));
      l0 = int'($urandom_range(0, 7));
      l1 = int'($urandom_range(0, 7));
      rr_pct[0] = int'($urandom_range(30, 100));
      rr_pct[1] = int'($urandom_range(30, 100));
      first = (sel == 3) ? 1 - model_last : (sel == 2 ? 1 : 0);
      exp_m.push_back(first);
      exp_l.push_back(first ? l1 : l0);
      if (sel == 3) begin
        exp_m.push_back(1 - first);
        exp_l.push_back(first ? l0 : l1);
      end
      model_last = exp_m[exp_m.size() - 1];
      if (sel & 1) begin req(0, int'($urandom_range(255)), l0); exp_beats[0] += l0 + 1; exp_bursts[0]++; end
      if (sel & 2) begin req(1, int'($urandom_range(255)), l1); exp_beats[1] += l1 + 1; exp_bursts[1]++; end
      run_until_idle(500, to);
      n_checks++; if (to) begin n_errors++; $display("FAIL rand_timeout: still busy, want idle"); end
    end
    rr_pct = '{100, 100};
    n_checks++; if (ar_mst_q.size() != exp_m.size()) begin n_errors++; $display("FAIL rand_grants: got %0d want %0d", ar_mst_q.size(), exp_m.size()); end
    for (int i = 0; i < exp_m.size() && i < ar_mst_q.size(); i++) begin
      n_checks++; if (ar_mst_q[i] != exp_m[i] || ar_len_q[i] != exp_l[i]) begin
        n_errors++; $display("FAIL rand_grant_%0d: got m%0d len %0d want m%0d len %0d", i, ar_mst_q[i], ar_len_q[i], exp_m[i], exp_l[i]);
      end
    end
    for (int m = 0; m < 2; m++) begin
      n_checks++; if (beats[m] != exp_beats[m] || last_seen[m] != exp_bursts[m]) begin
        n_errors++; $display("FAIL rand_beats_m%0d: got %0d beats %0d lasts want %0d/%0d", m, beats[m], last_seen[m], exp_beats[m], exp_bursts[m]);
      end
    end
    n_checks++; if (last_bad[0] + last_bad[1] + data_bad[0] + data_bad[1] + stray != 0 || protocol_err !== 1'b0) begin
      n_errors++; $display("FAIL rand_integrity: got errs=%0d perr=%0b want 0/0", last_bad[0] + last_bad[1] + data_bad[0] + data_bad[1] + stray, protocol_err);
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    ar_pct = 60; rv_pct = 70; inj_beat = -1;
    rr_pct = '{100, 100};
    data_open = 1'b0; cur_owner = 1'b0; prev_sarv = 1'b0; prev_err = 1'b0;
    slv_len = 0; slv_beat = 0; slv_data = '0; slv_resp = '0;
    areset = 1'b1;
    m0_if.araddr = '0; m0_if.arlen = '0; m0_if.arsize = '0; m0_if.arburst = '0; m0_if.arvalid = 1'b0; m0_if.rready = 1'b0;
    m1_if.araddr = '0; m1_if.arlen = '0; m1_if.arsize = '0; m1_if.arburst = '0; m1_if.arvalid = 1'b0; m1_if.rready = 1'b0;
    s_if.arready = 1'b0; s_if.rdata = '0; s_if.rresp = '0; s_if.rlast = 1'b0; s_if.rvalid = 1'b0;
    clear_logs();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_back_to_back();
    test_long_burst();
    test_rlast_err();
    test_midburst_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
